// File: rtl/gowin_tl_tx_adapter.sv
// RIFFA TX engine to Gowin PCIe TL TX port adapter: SOP/EOP framing, per-dword
// valid mask, two-entry skid buffering against tx_wait, framing checks and EOP counting.
module gowin_tl_tx_adapter #(
  parameter int unsigned C_PCI_DATA_WIDTH = 256,
  parameter int unsigned C_CNT_WIDTH      = 16
) (
  input  logic                        CLK,
  input  logic                        RST_N,
  input  logic [C_PCI_DATA_WIDTH-1:0] TX_DATA,
  input  logic                        TX_VALID,
  input  logic                        TX_START_FLAG,
  input  logic                        TX_END_FLAG,
  input  logic [2:0]                  TX_END_OFFSET,
  output logic                        TX_READY,
  output logic                        TL_TX_SOP,
  output logic                        TL_TX_EOP,
  output logic [C_PCI_DATA_WIDTH-1:0] TL_TX_DATA,
  output logic [7:0]                  TL_TX_VALID,
  input  logic                        TL_TX_WAIT,
  output logic                        PROTO_ERR,
  output logic [C_CNT_WIDTH-1:0]      PKT_COUNT
);

  typedef struct packed {
    logic                        sop;
    logic                        eop;
    logic [7:0]                  mask;
    logic [C_PCI_DATA_WIDTH-1:0] data;
  } beat_t;

  typedef enum logic {
    S_IDLE,
    S_PKT
  } state_t;

  state_t                 state_q, state_d;
  beat_t                  oreg_q, oreg_d;
  beat_t                  sreg_q, sreg_d;
  logic                   sreg_vld_q, sreg_vld_d;
  logic                   tx_ready_q, tx_ready_d;
  logic                   proto_err_q, proto_err_d;
  logic [C_CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;

  beat_t in_beat;
  logic  acc;
  logic  keep;
  logic  deliver;
  logic  oreg_free;

  // An empty OREG is encoded as an all-zero valid mask
  always_comb begin
    state_d     = state_q;
    oreg_d      = oreg_q;
    sreg_d      = sreg_q;
    sreg_vld_d  = sreg_vld_q;
    proto_err_d = 1'b0;
    pkt_count_d = pkt_count_q;
    in_beat     = '0;
    keep        = 1'b0;

    acc          = TX_VALID && tx_ready_q;
    in_beat.data = TX_DATA;
    in_beat.mask = 8'hFF;

    if (acc) begin
      unique case (state_q)
        S_IDLE: begin
          if (TX_START_FLAG) begin
            keep        = 1'b1;
            in_beat.sop = 1'b1;
            if (TX_END_FLAG) begin
              in_beat.eop  = 1'b1;
              in_beat.mask = 8'hFF >> (3'd7 - TX_END_OFFSET);
            end else begin
              state_d = S_PKT;
            end
          end else begin
            proto_err_d = 1'b1;
          end
        end
        S_PKT: begin
          keep        = 1'b1;
          proto_err_d = TX_START_FLAG;
          if (TX_END_FLAG) begin
            in_beat.eop  = 1'b1;
            in_beat.mask = 8'hFF >> (3'd7 - TX_END_OFFSET);
            state_d      = S_IDLE;
          end
        end
      endcase
    end

    deliver   = (oreg_q.mask != 8'h00) && !TL_TX_WAIT;
    oreg_free = (oreg_q.mask == 8'h00) || !TL_TX_WAIT;

    if (deliver && oreg_q.eop) begin
      pkt_count_d = pkt_count_q + C_CNT_WIDTH'(1);
    end

    // SREG always drains first so beat order is preserved
    if (oreg_free) begin
      if (sreg_vld_q) begin
        oreg_d     = sreg_q;
        sreg_vld_d = keep;
        if (keep) begin
          sreg_d = in_beat;
        end
      end else if (keep) begin
        oreg_d = in_beat;
      end else begin
        oreg_d = '0;
      end
    end else if (keep) begin
      sreg_d     = in_beat;
      sreg_vld_d = 1'b1;
    end

    tx_ready_d = !sreg_vld_d;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      oreg_q      <= '0;
      sreg_q      <= '0;
      sreg_vld_q  <= 1'b0;
      tx_ready_q  <= 1'b0;
      proto_err_q <= 1'b0;
      pkt_count_q <= '0;
    end else begin
      state_q     <= state_d;
      oreg_q      <= oreg_d;
      sreg_q      <= sreg_d;
      sreg_vld_q  <= sreg_vld_d;
      tx_ready_q  <= tx_ready_d;
      proto_err_q <= proto_err_d;
      pkt_count_q <= pkt_count_d;
    end
  end

  assign TX_READY    = tx_ready_q;
  assign TL_TX_SOP   = oreg_q.sop;
  assign TL_TX_EOP   = oreg_q.eop;
  assign TL_TX_DATA  = oreg_q.data;
  assign TL_TX_VALID = oreg_q.mask;
  assign PROTO_ERR   = proto_err_q;
  assign PKT_COUNT   = pkt_count_q;

endmodule

// File: tb/tb_gowin_tl_tx_adapter.sv
// Scoreboard bench for gowin_tl_tx_adapter: a driver pushes expected TL beats,
// a negedge monitor pops and compares every beat the DUT delivers.
module tb_gowin_tl_tx_adapter;

  localparam int unsigned DW = 256;
  localparam int unsigned CW = 4;

  logic          CLK = 1'b0;
  logic          RST_N = 1'b0;
  logic [DW-1:0] TX_DATA = '0;
  logic          TX_VALID = 1'b0;
  logic          TX_START_FLAG = 1'b0;
  logic          TX_END_FLAG = 1'b0;
  logic [2:0]    TX_END_OFFSET = 3'd0;
  logic          TX_READY;
  logic          TL_TX_SOP;
  logic          TL_TX_EOP;
  logic [DW-1:0] TL_TX_DATA;
  logic [7:0]    TL_TX_VALID;
  logic          TL_TX_WAIT = 1'b0;
  logic          PROTO_ERR;
  logic [CW-1:0] PKT_COUNT;

  always #5 CLK = ~CLK;

  gowin_tl_tx_adapter #(.C_PCI_DATA_WIDTH(DW), .C_CNT_WIDTH(CW)) dut (
    .CLK(CLK), .RST_N(RST_N), .TX_DATA(TX_DATA), .TX_VALID(TX_VALID),
    .TX_START_FLAG(TX_START_FLAG), .TX_END_FLAG(TX_END_FLAG),
    .TX_END_OFFSET(TX_END_OFFSET), .TX_READY(TX_READY),
    .TL_TX_SOP(TL_TX_SOP), .TL_TX_EOP(TL_TX_EOP), .TL_TX_DATA(TL_TX_DATA),
    .TL_TX_VALID(TL_TX_VALID), .TL_TX_WAIT(TL_TX_WAIT),
    .PROTO_ERR(PROTO_ERR), .PKT_COUNT(PKT_COUNT)
  );

  typedef struct packed {
    logic          sop;
    logic          eop;
    logic [7:0]    mask;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sbq[$];
  int   chk_cnt = 0;
  int   err_cnt = 0;
  int   acc_cnt = 0;
  int   stalls  = 0;

  task automatic check(input string name, input logic [271:0] act, input logic [271:0] exp);
    chk_cnt++;
    if (act !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int n);
    logic [DW-1:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = {16'(n), 16'(i)};
    return r;
  endfunction

  // Monitor: a beat is delivered at the next posedge when valid and not stalled
  always @(negedge CLK) begin : monitor
    exp_t e;
    if (RST_N && TL_TX_VALID != 8'h00 && !TL_TX_WAIT) begin
      if (sbq.size() == 0) begin
        chk_cnt++;
        err_cnt++;
        $display("FAIL unexpected_beat: got data %0h valid %0h, expected no beat", TL_TX_DATA, TL_TX_VALID);
      end else begin
        e = sbq.pop_front();
        check("tl_beat", 272'({TL_TX_SOP, TL_TX_EOP, TL_TX_VALID, TL_TX_DATA}), 272'(e));
      end
    end
  end

  task automatic send(input logic [DW-1:0] d, input logic s, input logic e, input logic [2:0] off,
                      input logic x_sop, input logic x_eop, input logic [7:0] x_mask,
                      input logic keep, input logic x_err);
    logic ok;
    int   n;
    exp_t x;
    TX_DATA = d; TX_START_FLAG = s; TX_END_FLAG = e; TX_END_OFFSET = off; TX_VALID = 1'b1;
    n = 0;
    do begin
      @(negedge CLK);
      ok = TX_READY;
      @(posedge CLK);
      if (!ok) stalls++;
      n++;
    end while (!ok && n < 200);
    if (!ok) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL accept_timeout: beat %0h not accepted within 200 cycles", d[31:0]);
    end else begin
      acc_cnt++;
      if (keep) begin
        x.sop = x_sop; x.eop = x_eop; x.mask = x_mask; x.data = d;
        sbq.push_back(x);
      end
    end
    #1;
    TX_VALID = 1'b0;
    check("proto_err", 272'(PROTO_ERR), 272'(x_err));
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(posedge CLK);
      n++;
    end
    if (sbq.size() != 0) begin
      chk_cnt++;
      err_cnt++;
      $display("FAIL drain_timeout: %0d beats still expected, 0 required", sbq.size());
    end
    @(posedge CLK);
    #1;
  endtask

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : stim
    int base;
    repeat (3) @(posedge CLK);
    #1;
    check("rst_ready", 272'(TX_READY), 272'(0));
    check("rst_outs", 272'({TL_TX_SOP, TL_TX_EOP, TL_TX_VALID, PROTO_ERR, PKT_COUNT}), 272'(0));
    check("rst_data", 272'(TL_TX_DATA), 272'(0));
    @(negedge CLK);
    RST_N = 1'b1;
    #1;
    check("ready_pre_edge", 272'(TX_READY), 272'(0));
    @(posedge CLK);
    #1;
    check("ready_post_edge", 272'(TX_READY), 272'(1));

    // Single-beat TLP
    send(mk(1), 1, 1, 3'd2, 1, 1, 8'h07, 1, 0);
    check("single_latency", 272'(TL_TX_VALID), 272'(8'h07));
    drain();
    check("pkt_count_single", 272'(PKT_COUNT), 272'(1));

    // Four-beat TLP, offsets on non-end beats must be ignored
    base = stalls;
    send(mk(10), 1, 0, 3'd3, 1, 0, 8'hFF, 1, 0);
    send(mk(11), 0, 0, 3'd5, 0, 0, 8'hFF, 1, 0);
    send(mk(12), 0, 0, 3'd0, 0, 0, 8'hFF, 1, 0);
    send(mk(13), 0, 1, 3'd7, 0, 1, 8'hFF, 1, 0);
    check("four_beat_no_stall", 272'(stalls - base), 272'(0));
    drain();
    check("pkt_count_four", 272'(PKT_COUNT), 272'(2));

    // Backpressure: WAIT high for 5 edges after the first beat lands in OREG
    base = acc_cnt;
    fork
      begin
        send(mk(20), 1, 0, 3'd0, 1, 0, 8'hFF, 1, 0);
        send(mk(21), 0, 0, 3'd0, 0, 0, 8'hFF, 1, 0);
        send(mk(22), 0, 0, 3'd0, 0, 0, 8'hFF, 1, 0);
        send(mk(23), 0, 0, 3'd0, 0, 0, 8'hFF, 1, 0);
        send(mk(24), 0, 0, 3'd0, 0, 0, 8'hFF, 1, 0);
        send(mk(25), 0, 1, 3'd4, 0, 1, 8'h1F, 1, 0);
      end
      begin
        int n;
        n = 0;
        do begin
          @(posedge CLK);
          #1;
          n++;
        end while (acc_cnt < base + 1 && n < 100);
        TL_TX_WAIT = 1'b1;
        repeat (5) @(posedge CLK);
        #1;
        check("bp_hold_data", 272'(TL_TX_DATA), 272'(mk(20)));
        check("bp_hold_sop", 272'({TL_TX_SOP, TL_TX_EOP, TL_TX_VALID}), 272'({1'b1, 1'b0, 8'hFF}));
        check("bp_extra_accept", 272'(acc_cnt - base), 272'(2));
        check("bp_ready_low", 272'(TX_READY), 272'(0));
        TL_TX_WAIT = 1'b0;
        @(posedge CLK);
        #1;
        check("bp_ready_back", 272'(TX_READY), 272'(1));
      end
    join
    drain();
    check("pkt_count_bp", 272'(PKT_COUNT), 272'(3));

    // Orphan beat in IDLE is dropped and flagged; next TLP passes intact
    send(mk(30), 0, 0, 3'd0, 0, 0, 8'h00, 0, 1);
    check("orphan_no_out", 272'(TL_TX_VALID), 272'(0));
    send(mk(31), 1, 0, 3'd0, 1, 0, 8'hFF, 1, 0);
    send(mk(32), 0, 1, 3'd0, 0, 1, 8'h01, 1, 0);
    drain();
    check("pkt_count_orphan", 272'(PKT_COUNT), 272'(4));

    // START inside a packet: flagged, beat still passes without SOP
    send(mk(33), 1, 0, 3'd0, 1, 0, 8'hFF, 1, 0);
    send(mk(34), 1, 0, 3'd0, 0, 0, 8'hFF, 1, 1);
    send(mk(35), 1, 1, 3'd3, 0, 1, 8'h0F, 1, 1);
    drain();
    check("pkt_count_restart", 272'(PKT_COUNT), 272'(5));

    // Counter wrap with a 4-bit counter: 17 TLPs from reset
    @(negedge CLK);
    RST_N = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    for (int i = 0; i < 17; i++) send(mk(40 + i), 1, 1, 3'd0, 1, 1, 8'h01, 1, 0);
    drain();
    check("pkt_count_wrap", 272'(PKT_COUNT), 272'(1));

    // Reset mid-packet with WAIT held high
    TL_TX_WAIT = 1'b1;
    send(mk(70), 1, 0, 3'd0, 1, 0, 8'hFF, 1, 0);
    send(mk(71), 0, 0, 3'd0, 0, 0, 8'hFF, 1, 0);
    TX_DATA = mk(72); TX_START_FLAG = 1'b0; TX_END_FLAG = 1'b0; TX_VALID = 1'b1;
    @(posedge CLK);
    #1;
    check("mid_ready_low", 272'(TX_READY), 272'(0));
    #2;
    RST_N = 1'b0;
    #1;
    check("mid_rst_outs", 272'({TL_TX_SOP, TL_TX_EOP, TL_TX_VALID, PROTO_ERR, PKT_COUNT, TX_READY}), 272'(0));
    check("mid_rst_data", 272'(TL_TX_DATA), 272'(0));
    sbq.delete();
    TX_VALID = 1'b0;
    TL_TX_WAIT = 1'b0;
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK);
    #1;
    send(mk(80), 1, 0, 3'd0, 1, 0, 8'hFF, 1, 0);
    send(mk(81), 0, 1, 3'd6, 0, 1, 8'h7F, 1, 0);
    drain();
    check("pkt_count_after_rst", 272'(PKT_COUNT), 272'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", chk_cnt, err_cnt);
    $finish;
  end

endmodule

// File: doc/gowin_tl_tx_adapter.md
# gowin_tl_tx_adapter

Transmit-side adapter between the RIFFA TX engine (256-bit TLP stream) and the Gowin PCIe controller transaction-layer TX port (`pcie_tl_tx_*`). It frames each TLP as SOP/EOP beats with a per-dword valid mask and obeys the controller's `tx_wait` backpressure through a two-entry skid buffer. It also polices start/end framing and counts transmitted packets. It sits in the Gowin top level, one clock domain with the TL clock, and drives the controller's TX inputs.

## Interface
- C_PCI_DATA_WIDTH, 256: datapath width; only 256 is supported (8 dwords per beat).
- C_CNT_WIDTH, 16: width of PKT_COUNT.
- CLK  in  1  TL clock, same as the controller's `pcie_tl_clk_i`.
- RST_N  in  1  reset; one clock; reset is asynchronous and active-low.
- TX_DATA  in  256  TLP beat from the TX engine; dword 0 is in bits [31:0].
- TX_VALID  in  1  beat valid.
- TX_START_FLAG  in  1  first beat of the TLP.
- TX_END_FLAG  in  1  last beat of the TLP.
- TX_END_OFFSET  in  3  index of the last valid dword in the end beat.
- TX_READY  out  1  adapter accepts a beat this cycle.
- TL_TX_SOP  out  1  to `pcie_tl_tx_sop_i`.
- TL_TX_EOP  out  1  to `pcie_tl_tx_eop_i`.
- TL_TX_DATA  out  256  to `pcie_tl_tx_data_i`.
- TL_TX_VALID  out  8  to `pcie_tl_tx_valid_i`, per-dword valid.
- TL_TX_WAIT  in  1  from `pcie_tl_tx_wait_o`; the controller stalls when this is high.
- PROTO_ERR  out  1  one-cycle pulse on a framing violation.
- PKT_COUNT  out  C_CNT_WIDTH  count of EOP beats delivered.

## Operation
- **Input handshake**
  - A beat is accepted when TX_VALID && TX_READY.
  - TX_READY is registered and equals !skid_full.
- **Output handshake**
  - A beat is delivered when TL_TX_VALID != 0 && !TL_TX_WAIT.
  - While TL_TX_WAIT is high, TL_TX_SOP, TL_TX_EOP, TL_TX_DATA and TL_TX_VALID hold stable.
- **Buffering**
  - The output register (OREG) is fed from the skid register (SREG) or directly from the input.
  - When OREG is empty or delivering, the next beat loads from SREG if SREG is full, else from the input.
  - An input beat that cannot enter OREG goes to SREG.
  - Order is preserved, no beat is dropped, and no beat is duplicated.
- **Framing FSM**, states IDLE and PKT, evaluated on accepted input beats:
  - IDLE, START && END: single-beat TLP, marked SOP and EOP; stay in IDLE.
  - IDLE, START && !END: marked SOP; go to PKT.
  - IDLE, !START: the beat is discarded (never reaches OREG); PROTO_ERR pulses.
  - PKT, END: marked EOP; go to IDLE. If START is also set, it is ignored and PROTO_ERR pulses.
  - PKT, START && !END: passed as a middle beat; PROTO_ERR pulses; stay in PKT.
  - PKT, neither flag: middle beat.
- **Valid mask**
  - Non-EOP beats: 8'hFF.
  - EOP beat: (2^(TX_END_OFFSET+1))-1, giving offset 0 → 8'h01, offset 3 → 8'h0F, offset 7 → 8'hFF.
  - TX_END_OFFSET is ignored on non-end beats.
- **PKT_COUNT**
  - Increments by 1 on each delivered beat with TL_TX_EOP=1.
  - Wraps modulo 2^C_CNT_WIDTH.

## Timing
- **Reset values**
  - TX_READY=0, then 1 on the first CLK edge after RST_N deasserts.
  - TL_TX_SOP=0, TL_TX_EOP=0, TL_TX_DATA=0, TL_TX_VALID=0, PROTO_ERR=0, PKT_COUNT=0.
  - FSM in IDLE; OREG and SREG empty.
- **Latency**
  - An accepted beat appears on TL_TX_* on the next cycle when OREG is free.
  - Sustained throughput is 1 beat/cycle with TL_TX_WAIT low.
- **Backpressure**
  - Once TL_TX_WAIT rises, at most one further input beat is accepted (into SREG).
  - TX_READY drops in the cycle after SREG fills.
  - When TL_TX_WAIT falls: OREG delivers, SREG moves to OREG, and TX_READY returns 1 one cycle later.
- **Simultaneous events**
  - SREG full, OREG delivering, and an input beat offered: impossible, since TX_READY is 0.
  - OREG delivering and an input beat accepted with SREG empty: the input loads directly into OREG.
- **PROTO_ERR** is asserted in the cycle after the offending beat is accepted.
- **Reset mid-packet**: all buffered beats are discarded and the outputs clear immediately (asynchronous). No EOP is synthesized.

## Test plan
- **Single-beat TLP**
  - Stimulus: START=END=1, OFFSET=2, data D0, TL_TX_WAIT=0.
  - Response: next cycle SOP=1, EOP=1, VALID=8'h07, DATA=D0; PKT_COUNT 0→1.
- **Four-beat TLP, no stalls**
  - Stimulus: OFFSET=7 on the last beat.
  - Response: 4 consecutive output beats; SOP only on the first, EOP only on the last; all VALID=8'hFF; TX_READY stays 1.
- **Backpressure**
  - Stimulus: TL_TX_WAIT=1 for 5 cycles mid-stream of a 6-beat TLP.
  - Response: outputs hold; exactly one extra beat is accepted; TX_READY=0 until one cycle after WAIT falls; all 6 beats delivered in order.
- **Orphan beat**
  - Stimulus: TX_VALID with START=0 in IDLE.
  - Response: PROTO_ERR pulses once; nothing appears on TL_TX_*; a following well-formed TLP passes intact.
- **Counter wrap**
  - Stimulus: C_CNT_WIDTH=4, 17 single-beat TLPs.
  - Response: PKT_COUNT=1.
- **Reset mid-packet**
  - Stimulus: RST_N low during beat 2 of 4, with WAIT held high.
  - Response: all outputs 0 immediately; after release, a new TLP starts with SOP and the FSM is in IDLE.
